// File: rtl/play_scheduler.sv
// Sequences one song from the song ROM into timed note/gap intervals for the tone generator.
// Latency: start -> FETCH next cycle, ROM word one cycle later, note_valid from the third cycle.
// Backpressure: none downstream; pause freezes PLAY/GAP counts, stop aborts to IDLE.
module play_scheduler #(
  parameter int TICK_DIV = 1_000_000,
  parameter int GAP_CYC  = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] song_num,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [4:0] note,
  output logic       note_valid,
  output logic       busy,
  output logic       done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state;
  logic [1:0]    song_q;
  logic [5:0]    idx;
  logic [2:0]    dur_q;
  logic [2:0]    unit_cnt;
  logic [TW-1:0] tick_cnt;
  logic [GW-1:0] gap_cnt;

  // Address is always the latched song and current index; only FETCH makes it meaningful.
  assign rom_addr   = {song_q, idx};
  assign note_valid = (state == S_PLAY) && !pause;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      song_q   <= '0;
      idx      <= '0;
      dur_q    <= '0;
      unit_cnt <= '0;
      tick_cnt <= '0;
      gap_cnt  <= '0;
      note     <= '0;
    end else if (stop) begin
      state    <= S_IDLE;
      unit_cnt <= '0;
      tick_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            song_q <= song_num;
            idx    <= '0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (rom_data[4:0] == 5'h1F || rom_data[7:5] == 3'd0) begin
            state <= S_DONE;
          end else begin
            note     <= rom_data[4:0];
            dur_q    <= rom_data[7:5];
            tick_cnt <= '0;
            unit_cnt <= '0;
            state    <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (!pause) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (unit_cnt == dur_q - 3'd1) begin
                gap_cnt <= '0;
                state   <= S_GAP;
              end else begin
                unit_cnt <= unit_cnt + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (!pause) begin
            if (gap_cnt == GAP_LAST) begin
              // Index 63 is the last slot; it ends the song rather than wrapping.
              if (idx == 6'd63) begin
                state <= S_DONE;
              end else begin
                idx   <= idx + 6'd1;
                state <= S_FETCH;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_play_scheduler.sv
// Bench for play_scheduler: song ROM model plus a per-cycle timeline model of expected outputs.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled on the falling edge.
// Backpressure: exercised through pause windows and stop pulses.
module tb_play_scheduler;

  localparam int TICK = 4;
  localparam int GAP  = 2;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] song_num;
  logic       start;
  logic       pause;
  logic       stop;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [4:0] note;
  logic       note_valid;
  logic       busy;
  logic       done;

  logic [7:0] rom [256];

  int n_chk  = 0;
  int n_pass = 0;

  bit         e_busy     [MAXC];
  bit         e_nv       [MAXC];
  bit         e_done     [MAXC];
  bit         e_addr_chk [MAXC];
  logic [7:0] e_addr     [MAXC];
  bit         e_note_chk [MAXC];
  logic [4:0] e_note     [MAXC];
  int         n_cyc;

  play_scheduler #(.TICK_DIV(TICK), .GAP_CYC(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .song_num   (song_num),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note       (note),
    .note_valid (note_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM: word valid the cycle after its address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected timeline: cycle 0 carries the start pulse; each note is fetch, wait,
  // dur*TICK unpaused high cycles, GAP unpaused silent cycles.
  task automatic build_model(input logic [1:0] s, input int ps, input int pl);
    int c;
    int rem;
    bit fin;
    logic [7:0] w;
    logic [7:0] a;
    for (int k = 0; k < MAXC; k++) begin
      e_busy[k] = 0; e_nv[k] = 0; e_done[k] = 0;
      e_addr_chk[k] = 0; e_addr[k] = '0; e_note_chk[k] = 0; e_note[k] = '0;
    end
    c = 1;
    fin = 0;
    for (int i = 0; i < 64 && !fin; i++) begin
      a = {s, 6'(i)};
      e_busy[c] = 1; e_addr_chk[c] = 1; e_addr[c] = a; c++;
      e_busy[c] = 1; c++;
      w = rom[a];
      if (w[4:0] == 5'h1F || w[7:5] == 3'd0) begin
        e_busy[c] = 1; e_done[c] = 1; c++; fin = 1;
      end else begin
        rem = int'(w[7:5]) * TICK;
        while (rem > 0) begin
          e_busy[c] = 1; e_note_chk[c] = 1; e_note[c] = w[4:0];
          if (!(c >= ps && c < ps + pl)) begin e_nv[c] = 1; rem--; end
          c++;
        end
        rem = GAP;
        while (rem > 0) begin
          e_busy[c] = 1; e_note_chk[c] = 1; e_note[c] = w[4:0];
          if (!(c >= ps && c < ps + pl)) rem--;
          c++;
        end
        if (i == 63) begin e_busy[c] = 1; e_done[c] = 1; c++; fin = 1; end
      end
    end
    n_cyc = c;
  endtask

  task automatic run_song(input logic [1:0] s, input int ps, input int pl, input bit toggle);
    build_model(s, ps, pl);
    for (int c = 0; c < n_cyc + 2; c++) begin
      @(posedge clk); #1;
      start    = (c == 0);
      stop     = 1'b0;
      song_num = (c == 0 || !toggle) ? s : 2'($urandom);
      pause    = (c >= ps && c < ps + pl);
      @(negedge clk);
      chk($sformatf("s%0d_c%0d_busy", s, c), 32'(busy), 32'(e_busy[c]));
      chk($sformatf("s%0d_c%0d_done", s, c), 32'(done), 32'(e_done[c]));
      chk($sformatf("s%0d_c%0d_nv", s, c), 32'(note_valid), 32'(e_nv[c]));
      if (e_addr_chk[c]) chk($sformatf("s%0d_c%0d_addr", s, c), 32'(rom_addr), 32'(e_addr[c]));
      if (e_note_chk[c]) chk($sformatf("s%0d_c%0d_note", s, c), 32'(note), 32'(e_note[c]));
    end
    pause = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_nv"}, 32'(note_valid), 0);
    chk({tag, "_note"}, 32'(note), 0);
    chk({tag, "_addr"}, 32'(rom_addr), 0);
  endtask

  initial begin
    rst_n = 1'b0; song_num = 2'd0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h1F;
    rom[8'h80] = {3'd2, 5'd5};
    rom[8'h81] = 8'h1F;
    for (int i = 0; i < 64; i++) rom[i] = {3'd1, 5'd1};
    for (int i = 0; i < 64; i++) begin
      rom[8'h40 + i] = {3'($urandom_range(1, 3)), 5'($urandom_range(0, 30))};
      rom[8'hC0 + i] = {3'($urandom_range(1, 3)), 5'($urandom_range(0, 30))};
    end
    rom[8'h40 + $urandom_range(2, 12)] = 8'h1F;
    rom[8'hC0 + 20] = {3'd0, 5'($urandom_range(0, 30))};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Single two-unit note then terminator, without and with a pause window.
    run_song(2'd2, 0, 0, 0);
    run_song(2'd2, 5, 5, 0);

    // Stop mid-note: idle next cycle, no done pulse, restart from index 0.
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      start = (c == 0); song_num = 2'd2; stop = (c == 6);
      @(negedge clk);
      if (c == 6) chk("stop_c6_busy", 32'(busy), 1);
      if (c == 7) begin
        chk("stop_c7_busy", 32'(busy), 0);
        chk("stop_c7_nv", 32'(note_valid), 0);
      end
    end
    for (int c = 8; c < 20; c++) begin
      @(posedge clk); #1 start = 1'b0; stop = 1'b0;
      @(negedge clk);
      chk($sformatf("stop_c%0d_done", c), 32'(done), 0);
    end
    run_song(2'd2, 0, 0, 0);

    // Full 64-entry song with song_num wandering while busy.
    run_song(2'd0, 0, 0, 1);

    // Randomized songs and pause windows.
    for (int r = 0; r < 4; r++) begin
      run_song(2'd1, $urandom_range(3, 40), $urandom_range(1, 12), 1);
      run_song(2'd3, $urandom_range(3, 60), $urandom_range(1, 12), 1);
    end

    // Asynchronous reset pulse inside the gap, no rising edge while low.
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      start = (c == 0); song_num = 2'd2;
      @(negedge clk);
      if (c == 10) chk("rst_pre_busy", 32'(busy), 1);
    end
    @(posedge clk); #1 start = 1'b0; rst_n = 1'b0;
    #2 chk_all_zero("rst_mid_gap");
    #1 rst_n = 1'b1;
    run_song(2'd2, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
